// File: rtl/row_cmd_issuer.sv
// DRAM command sequencer: walks one request through PRE/ACT/RD/WR against the
// open-row tracker's status, and runs precharge-all + REF for refresh.
module row_cmd_issuer #(
    parameter int unsigned BG_BITS   = 2,
    parameter int unsigned BANK_BITS = 2,
    parameter int unsigned ROW_BITS  = 16,
    parameter int unsigned COL_BITS  = 10,
    parameter int unsigned T_RP      = 4,
    parameter int unsigned T_RCD     = 4,
    parameter int unsigned T_CAS     = 4,
    parameter int unsigned T_RFC     = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [BG_BITS-1:0]   req_bg,
    input  logic [BANK_BITS-1:0] req_bank,
    input  logic [ROW_BITS-1:0]  req_row,
    input  logic [COL_BITS-1:0]  req_col,
    input  logic [1:0]           row_stat,
    input  logic [ROW_BITS-1:0]  row_conflict,
    output logic                 req_en,
    output logic                 row_resolve,
    output logic                 act_done,
    output logic                 ref_done,
    input  logic                 ref_req,
    output logic                 ref_ack,
    output logic                 cmd_valid,
    output logic [2:0]           cmd,
    output logic [BG_BITS-1:0]   cmd_bg,
    output logic [BANK_BITS-1:0] cmd_bank,
    output logic [ROW_BITS-1:0]  cmd_row,
    output logic [COL_BITS-1:0]  cmd_col,
    output logic                 rsp_done,
    output logic                 busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_DECODE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD,
        S_RW, S_WAIT_CAS, S_PREA, S_WAIT_PRA, S_REF, S_WAIT_RFC
    } state_t;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'b000,
        CMD_ACT  = 3'b001,
        CMD_PRE  = 3'b010,
        CMD_RD   = 3'b011,
        CMD_WR   = 3'b100,
        CMD_REF  = 3'b101,
        CMD_PREA = 3'b110
    } cmd_t;

    localparam int unsigned T_MAX_A = (T_RP  > T_RCD) ? T_RP  : T_RCD;
    localparam int unsigned T_MAX_B = (T_CAS > T_RFC) ? T_CAS : T_RFC;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int unsigned CNT_W   = $clog2(T_MAX) + 1;

    // The command cycle itself is the first of the T_x cycles, so the wait
    // state holds for T_x-1 cycles: load T_x-2 and leave when it reads 0.
    localparam int unsigned RP_LD_I  = (T_RP  > 1) ? T_RP  - 2 : 0;
    localparam int unsigned RCD_LD_I = (T_RCD > 1) ? T_RCD - 2 : 0;
    localparam int unsigned CAS_LD_I = (T_CAS > 1) ? T_CAS - 2 : 0;
    localparam int unsigned RFC_LD_I = (T_RFC > 1) ? T_RFC - 2 : 0;
    localparam logic [CNT_W-1:0] RP_LD  = CNT_W'(RP_LD_I);
    localparam logic [CNT_W-1:0] RCD_LD = CNT_W'(RCD_LD_I);
    localparam logic [CNT_W-1:0] CAS_LD = CNT_W'(CAS_LD_I);
    localparam logic [CNT_W-1:0] RFC_LD = CNT_W'(RFC_LD_I);

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   wr_q;
    logic [BG_BITS-1:0]     bg_q;
    logic [BANK_BITS-1:0]   bank_q;
    logic [ROW_BITS-1:0]    row_q;
    logic [COL_BITS-1:0]    col_q;
    cmd_t                   cmd_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            bg_q    <= '0;
            bank_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ref_req) begin
                        state_q <= S_PREA;
                    end else if (req_valid) begin
                        wr_q    <= req_write;
                        bg_q    <= req_bg;
                        bank_q  <= req_bank;
                        row_q   <= req_row;
                        col_q   <= req_col;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (row_stat)
                        2'b01:   state_q <= S_RW;
                        2'b11:   state_q <= S_PRE;
                        default: state_q <= S_ACT;
                    endcase
                end
                S_PRE: begin
                    cnt_q   <= RP_LD;
                    state_q <= (T_RP > 1) ? S_WAIT_RP : S_ACT;
                end
                S_WAIT_RP: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= S_ACT;
                end
                S_ACT: begin
                    cnt_q   <= RCD_LD;
                    state_q <= (T_RCD > 1) ? S_WAIT_RCD : S_RW;
                end
                S_WAIT_RCD: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= S_RW;
                end
                // A refresh raised mid-request goes straight to PREA on completion.
                S_RW: begin
                    cnt_q <= CAS_LD;
                    if (T_CAS > 1) state_q <= S_WAIT_CAS;
                    else           state_q <= ref_req ? S_PREA : S_IDLE;
                end
                S_WAIT_CAS: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= ref_req ? S_PREA : S_IDLE;
                end
                S_PREA: begin
                    cnt_q   <= RP_LD;
                    state_q <= (T_RP > 1) ? S_WAIT_PRA : S_REF;
                end
                S_WAIT_PRA: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= S_REF;
                end
                S_REF: begin
                    cnt_q   <= RFC_LD;
                    state_q <= (T_RFC > 1) ? S_WAIT_RFC : S_IDLE;
                end
                S_WAIT_RFC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        cmd_d       = CMD_NOP;
        row_resolve = 1'b0;
        act_done    = 1'b0;
        ref_done    = 1'b0;
        rsp_done    = 1'b0;
        ref_ack     = 1'b0;
        req_en      = 1'b0;
        cmd_row     = row_q;
        case (state_q)
            S_DECODE:   req_en = 1'b1;
            S_PRE: begin
                cmd_d       = CMD_PRE;
                cmd_row     = row_conflict;
                row_resolve = 1'b1;
                req_en      = 1'b1;
            end
            S_WAIT_RP:  req_en = 1'b1;
            S_ACT: begin
                cmd_d    = CMD_ACT;
                act_done = 1'b1;
                req_en   = 1'b1;
            end
            S_WAIT_RCD: req_en = 1'b1;
            S_RW: begin
                cmd_d    = wr_q ? CMD_WR : CMD_RD;
                req_en   = 1'b1;
                rsp_done = (T_CAS == 1);
            end
            S_WAIT_CAS: rsp_done = (cnt_q == '0);
            S_PREA:     cmd_d = CMD_PREA;
            S_REF: begin
                cmd_d    = CMD_REF;
                ref_done = 1'b1;
                ref_ack  = (T_RFC == 1);
            end
            S_WAIT_RFC: ref_ack = (cnt_q == '0);
            default: ;
        endcase
    end

    assign cmd       = cmd_d;
    assign cmd_valid = (cmd_d != CMD_NOP);
    assign cmd_bg    = bg_q;
    assign cmd_bank  = bank_q;
    assign cmd_col   = col_q;
    assign busy      = (state_q != S_IDLE);
    // Gated by nRST so every output reads 0 while reset is held.
    assign req_ready = nRST && (state_q == S_IDLE) && !ref_req;

endmodule
